// File: rtl/ps2_mouse_rx.sv
// Receive-only PS/2 mouse deserialiser and 3-byte packet assembler.
// Optional PS2_MOUSE_SYNC_CHECK_EN: a byte 0 candidate with bit3 clear is dropped to realign packets.
`timescale 1ns/1ps
module ps2_mouse_rx #(
    parameter int FILTER_LEN  = 8,
    parameter int BIT_TIMEOUT = 50000,
    parameter int PKT_TIMEOUT = 200000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [24:0] ps2_mouse,
    output logic        frame_err
);

    localparam int FW  = $clog2(FILTER_LEN + 1);
    localparam int BTW = $clog2(BIT_TIMEOUT + 1);
    localparam int PTW = $clog2(PKT_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Both pins reset high so release from reset never looks like a falling edge.
    logic [1:0] pin_raw;
    logic [1:0] pin_sync;
    assign pin_raw = {ps2_data, ps2_clk};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_q;
            logic sync_q;
            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    meta_q <= 1'b1;
                    sync_q <= 1'b1;
                end else begin
                    meta_q <= pin_raw[gi];
                    sync_q <= meta_q;
                end
            end
            assign pin_sync[gi] = sync_q;
        end
    endgenerate

    logic clk_s;
    logic data_s;
    assign clk_s  = pin_sync[0];
    assign data_s = pin_sync[1];

    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall;

    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        fall   = 1'b0;
        if (clk_s != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = clk_s;
                fall   = filt_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    state_t         state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           perr_q, perr_d;
    logic [1:0]     byte_idx_q, byte_idx_d;
    logic [7:0]     b0_q, b0_d;
    logic [7:0]     b1_q, b1_d;
    logic [24:0]    mouse_q, mouse_d;
    logic           err_q, err_d;
    logic [BTW-1:0] bto_q, bto_d;
    logic [PTW-1:0] pto_q, pto_d;
    logic           skip;

    always_comb begin
        skip = 1'b0;
`ifdef PS2_MOUSE_SYNC_CHECK_EN
        skip = (byte_idx_q == 2'd0) && !shift_q[3];
`endif
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        byte_idx_d = byte_idx_q;
        b0_d       = b0_q;
        b1_d       = b1_q;
        mouse_d    = mouse_q;
        err_d      = 1'b0;
        bto_d      = bto_q;
        pto_d      = pto_q;

        if (fall) begin
            bto_d = '0;
            pto_d = '0;
            case (state_q)
                IDLE: begin
                    if (!data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    perr_d  = ~((^shift_q) ^ data_s);
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!data_s || perr_q) begin
                        err_d      = 1'b1;
                        byte_idx_d = 2'd0;
                    end else if (!skip) begin
                        case (byte_idx_q)
                            2'd0: begin
                                b0_d       = shift_q;
                                byte_idx_d = 2'd1;
                            end
                            2'd1: begin
                                b1_d       = shift_q;
                                byte_idx_d = 2'd2;
                            end
                            default: begin
                                mouse_d    = {~mouse_q[24], shift_q, b1_q, b0_q};
                                byte_idx_d = 2'd0;
                            end
                        endcase
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            // Stalled frame: abandon it and any partially built packet.
            if (state_q != IDLE) begin
                if (bto_q >= BTW'(BIT_TIMEOUT - 1)) begin
                    state_d    = IDLE;
                    byte_idx_d = 2'd0;
                    err_d      = 1'b1;
                    bto_d      = '0;
                end else begin
                    bto_d = bto_q + 1'b1;
                end
            end else begin
                bto_d = '0;
            end

            if (state_q == IDLE && byte_idx_q != 2'd0) begin
                if (pto_q >= PTW'(PKT_TIMEOUT - 1)) begin
                    byte_idx_d = 2'd0;
                    pto_d      = '0;
                end else begin
                    pto_d = pto_q + 1'b1;
                end
            end else begin
                pto_d = '0;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'd0;
            perr_q     <= 1'b0;
            byte_idx_q <= 2'd0;
            b0_q       <= 8'd0;
            b1_q       <= 8'd0;
            mouse_q    <= 25'd0;
            err_q      <= 1'b0;
            bto_q      <= '0;
            pto_q      <= '0;
        end else begin
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            byte_idx_q <= byte_idx_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
            mouse_q    <= mouse_d;
            err_q      <= err_d;
            bto_q      <= bto_d;
            pto_q      <= pto_d;
        end
    end

    assign ps2_mouse = mouse_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_mouse_rx.sv
// Scoreboard bench for ps2_mouse_rx: packets are queued as bytes are sent and popped on bit-24 toggles.
`timescale 1ns/1ps
module tb_ps2_mouse_rx;

    localparam int FILTER_LEN  = 8;
    localparam int BIT_TIMEOUT = 500;
    localparam int PKT_TIMEOUT = 2000;
    localparam int HALF        = 40;
    localparam int GAP         = 100;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [24:0] ps2_mouse;
    logic        frame_err;

    ps2_mouse_rx #(
        .FILTER_LEN (FILTER_LEN),
        .BIT_TIMEOUT(BIT_TIMEOUT),
        .PKT_TIMEOUT(PKT_TIMEOUT)
    ) dut (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_mouse(ps2_mouse),
        .frame_err(frame_err)
    );

    always #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end else begin
            $display("ok   %s value=%h", tag, obs);
        end
    endtask

    // Scoreboard and reference packet assembler
    logic [23:0] exp_q[$];
    logic [7:0]  m_b0, m_b1;
    int          m_idx    = 0;
    int          err_exp  = 0;
    int          err_seen = 0;
    int          pkt_exp  = 0;
    int          pkt_seen = 0;
    logic        prev_tog = 1'b0;

    always @(negedge clk_sys) begin
        if (!reset_n) begin
            prev_tog = 1'b0;
        end else begin
            if (frame_err) err_seen++;
            if (ps2_mouse[24] != prev_tog) begin
                prev_tog = ps2_mouse[24];
                pkt_seen++;
                check_val("pkt_avail", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check_val("pkt_data", 32'(ps2_mouse[23:0]), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    // Shift out nbits of an LSB-first frame; glitch_bit>=0 puts a 2-cycle low pulse in that bit's high phase.
    task automatic send_bits(input logic [10:0] frame, input int nbits, input int glitch_bit);
        for (int i = 0; i < nbits; i++) begin
            ps2_data = frame[i];
            wait_cycles(HALF / 4);
            if (i == glitch_bit) begin
                ps2_clk = 1'b0;
                wait_cycles(2);
                ps2_clk = 1'b1;
            end
            wait_cycles(HALF / 4);
            ps2_clk = 1'b0;
            wait_cycles(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic model_byte(input logic [7:0] b, input logic bad_par);
        logic skip;
        skip = 1'b0;
`ifdef PS2_MOUSE_SYNC_CHECK_EN
        skip = (m_idx == 0) && !b[3];
`endif
        if (bad_par) begin
            err_exp++;
            m_idx = 0;
        end else if (!skip) begin
            if (m_idx == 0) begin
                m_b0 = b; m_idx = 1;
            end else if (m_idx == 1) begin
                m_b1 = b; m_idx = 2;
            end else begin
                exp_q.push_back({b, m_b1, m_b0});
                pkt_exp++;
                m_idx = 0;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par, input int glitch_bit);
        model_byte(b, bad_par);
        send_bits(make_frame(b, bad_par), 11, glitch_bit);
        wait_cycles(GAP);
    endtask

    task automatic idle(input int n);
        wait_cycles(n);
        if (n > PKT_TIMEOUT) m_idx = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_cycles(5);
        check_val("rst_mouse", 32'(ps2_mouse), 32'd0);
        check_val("rst_err", 32'(frame_err), 32'd0);
        reset_n = 1'b1;
        wait_cycles(20);

        // Basic packet
        send_byte(8'h09, 1'b0, -1);
        send_byte(8'h05, 1'b0, -1);
        send_byte(8'hFB, 1'b0, -1);
        check_val("pkt1_drained", 32'(exp_q.size()), 32'd0);
        check_val("pkt1_tog", 32'(ps2_mouse[24]), 32'd1);
        check_val("pkt1_val", 32'(ps2_mouse[23:0]), 32'hFB0509);

        // Parity error on byte 1, then a clean packet
        send_byte(8'h08, 1'b0, -1);
        send_byte(8'h10, 1'b1, -1);
        check_val("par_err", 32'(err_seen), 32'(err_exp));
        check_val("par_no_tog", 32'(ps2_mouse[24]), 32'd1);
        send_byte(8'h08, 1'b0, -1);
        send_byte(8'h10, 1'b0, -1);
        send_byte(8'h20, 1'b0, -1);

        // Partial frame stalls past the bit timeout
        send_bits(make_frame(8'h55, 1'b0), 5, -1);
        wait_cycles(BIT_TIMEOUT + 200);
        err_exp++;
        m_idx = 0;
        check_val("bit_to_err", 32'(err_seen), 32'(err_exp));
        send_byte(8'h18, 1'b0, -1);
        send_byte(8'h7F, 1'b0, -1);
        send_byte(8'h80, 1'b0, -1);

        // Packet timeout between bytes
        send_byte(8'h09, 1'b0, -1);
        send_byte(8'h05, 1'b0, -1);
        idle(PKT_TIMEOUT + 500);
        send_byte(8'h0A, 1'b0, -1);
        send_byte(8'h01, 1'b0, -1);
        send_byte(8'h02, 1'b0, -1);
        check_val("pkt_to_err", 32'(err_seen), 32'(err_exp));

        // Alignment: leading byte with bit3 clear
        send_byte(8'h01, 1'b0, -1);
        send_byte(8'h09, 1'b0, -1);
        send_byte(8'h03, 1'b0, -1);
        send_byte(8'h04, 1'b0, -1);
        idle(PKT_TIMEOUT + 500);
        check_val("align_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of byte 2
        send_byte(8'h08, 1'b0, -1);
        send_byte(8'h01, 1'b0, -1);
        send_bits(make_frame(8'h77, 1'b0), 5, -1);
        reset_n = 1'b0;
        #1;
        check_val("midrst_mouse", 32'(ps2_mouse), 32'd0);
        check_val("midrst_err", 32'(frame_err), 32'd0);
        m_idx = 0;
        wait_cycles(5);
        reset_n = 1'b1;
        wait_cycles(20);
        send_byte(8'h28, 1'b0, -1);
        send_byte(8'hF0, 1'b0, -1);
        send_byte(8'h0F, 1'b0, -1);
        check_val("postrst_val", 32'(ps2_mouse), 32'h10FF028);

        // Short clock glitches must not shift bits
        send_byte(8'h09, 1'b0, 3);
        send_byte(8'h33, 1'b0, 8);
        send_byte(8'h44, 1'b0, 0);

        wait_cycles(50);
        check_val("final_drained", 32'(exp_q.size()), 32'd0);
        check_val("final_errs", 32'(err_seen), 32'(err_exp));
        check_val("final_pkts", 32'(pkt_seen), 32'(pkt_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
